// File: rtl/pc_sequencer.sv
// PC sequencer: turns NEXT/JUMP/CALL/RET requests into one-cycle PC bank strobes
// and tracks call depth, latching a sticky fault on call overflow or return underflow.
module pc_sequencer #(
  parameter int PC_W   = 9,
  parameter int LEVELS = 8,
  localparam int DW    = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [1:0]      req_op,
  input  logic [PC_W-1:0] req_target,
  output logic            req_ready,
  output logic            pc_inc,
  output logic            pc_ref_inc,
  output logic            pc_ref_dec,
  output logic            pc_set,
  output logic [PC_W-1:0] pc_set_value,
  output logic [DW-1:0]   depth,
  output logic            done,
  output logic            fault,
  output logic [1:0]      fault_code,
  output logic [1:0]      state_dbg
);

  // Handshake: a request transfers on a posedge where req_valid && req_ready;
  // req_ready is high only in IDLE outside reset, and op/target are ignored otherwise.
  typedef enum logic [1:0] {IDLE, CALL_SET, RET_INC, FAULT} state_t;

  localparam logic [1:0] OP_NEXT = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;
  localparam logic [DW-1:0] MAX_DEPTH = DW'(LEVELS - 1);

  state_t          state, state_d;
  logic [DW-1:0]   depth_d;
  logic [PC_W-1:0] target_q, target_d, set_value_d;
  logic            inc_d, ref_inc_d, ref_dec_d, set_d, done_d, fault_d;
  logic [1:0]      fault_code_d;

  assign req_ready = (state == IDLE) && !rst;
  assign state_dbg = state;

  always_comb begin
    state_d      = state;
    depth_d      = depth;
    target_d     = target_q;
    set_value_d  = pc_set_value;
    inc_d        = 1'b0;
    ref_inc_d    = 1'b0;
    ref_dec_d    = 1'b0;
    set_d        = 1'b0;
    done_d       = 1'b0;
    fault_d      = fault;
    fault_code_d = fault_code;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_NEXT: begin
              inc_d  = 1'b1;
              done_d = 1'b1;
            end
            OP_JUMP: begin
              set_d       = 1'b1;
              set_value_d = req_target;
              done_d      = 1'b1;
            end
            OP_CALL: begin
              if (depth == MAX_DEPTH) begin
                fault_d      = 1'b1;
                fault_code_d = 2'b01;
                state_d      = FAULT;
              end else begin
                ref_inc_d = 1'b1;
                depth_d   = depth + DW'(1);
                target_d  = req_target;
                state_d   = CALL_SET;
              end
            end
            OP_RET: begin
              if (depth == '0) begin
                fault_d      = 1'b1;
                fault_code_d = 2'b10;
                state_d      = FAULT;
              end else begin
                ref_dec_d = 1'b1;
                depth_d   = depth - DW'(1);
                state_d   = RET_INC;
              end
            end
          endcase
        end
      end
      // Second half of CALL: load the target captured at acceptance.
      CALL_SET: begin
        set_d       = 1'b1;
        set_value_d = target_q;
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      RET_INC: begin
        inc_d   = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      FAULT: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      depth        <= '0;
      target_q     <= '0;
      pc_set_value <= '0;
      pc_inc       <= 1'b0;
      pc_ref_inc   <= 1'b0;
      pc_ref_dec   <= 1'b0;
      pc_set       <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= 2'b00;
    end else begin
      state        <= state_d;
      depth        <= depth_d;
      target_q     <= target_d;
      pc_set_value <= set_value_d;
      pc_inc       <= inc_d;
      pc_ref_inc   <= ref_inc_d;
      pc_ref_dec   <= ref_dec_d;
      pc_set       <= set_d;
      done         <= done_d;
      fault        <= fault_d;
      fault_code   <= fault_code_d;
    end
  end

endmodule
